// File: rtl/alu_exec_unit.sv
// Registered, handshaked ALU execute stage: add/sub/and/or/slt in one cycle, with an optional
// iterative shift-add multiplier on code 3'b110 enabled by defining ALU_MUL_EN.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             OverFlow,
   output logic             busy
);

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpAnd = 3'b010;
   localparam logic [2:0] OpOr  = 3'b011;
   localparam logic [2:0] OpSlt = 3'b101;
   localparam logic [2:0] OpMul = 3'b110;

   if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
      $error("CNT_W too small to count WIDTH iterations");
   end

   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             accept;
   logic             retire;

   // Shared adder; slt reuses the subtract path.
   always_comb begin
      is_sub  = (ALUControl == OpSub) || (ALUControl == OpSlt);
      b_eff   = is_sub ? ~SrcB : SrcB;
      sum_ext = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      sum     = sum_ext[WIDTH-1:0];
      cout    = sum_ext[WIDTH];
      ovf     = (SrcA[WIDTH-1] ~^ b_eff[WIDTH-1]) & (sum[WIDTH-1] ^ SrcA[WIDTH-1]);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (ALUControl)
         OpAdd, OpSub: begin
            alu_res = sum;
            alu_c   = cout;
            alu_v   = ovf;
         end
         OpAnd:   alu_res = SrcA & SrcB;
         OpOr:    alu_res = SrcA | SrcB;
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
         default: alu_res = '0;
      endcase
   end

   assign accept = in_valid & in_ready;
   assign retire = out_valid & out_ready;

`ifdef ALU_MUL_EN
   typedef enum logic {StIdle, StMul} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign in_ready = ~rst & (state == StIdle) & (~out_valid | out_ready);
   assign busy     = (state == StMul);
`else
   assign in_ready = ~rst & (~out_valid | out_ready);
   assign busy     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         Result    <= '0;
         Zero      <= 1'b0;
         Negative  <= 1'b0;
         Carry     <= 1'b0;
         OverFlow  <= 1'b0;
`ifdef ALU_MUL_EN
         state     <= StIdle;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
`endif
      end else begin
         if (retire) out_valid <= 1'b0;
`ifdef ALU_MUL_EN
         if (state == StMul) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == '0) begin
               Result    <= acc_next;
               Zero      <= (acc_next == '0);
               Negative  <= acc_next[WIDTH-1];
               Carry     <= 1'b0;
               OverFlow  <= 1'b0;
               out_valid <= 1'b1;
               state     <= StIdle;
            end
         end else
`endif
         if (accept) begin
`ifdef ALU_MUL_EN
            if (ALUControl == OpMul) begin
               mcand  <= SrcA;
               mplier <= SrcB;
               acc    <= '0;
               cnt    <= CNT_W'(WIDTH - 1);
               state  <= StMul;
            end else
`endif
            begin
               Result    <= alu_res;
               Zero      <= (alu_res == '0);
               Negative  <= alu_res[WIDTH-1];
               Carry     <= alu_c;
               OverFlow  <= alu_v;
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule
